// File: rtl/pixel_frame_feeder.sv
// Frame buffer feeder: loads one IMG_W x IMG_W frame byte-by-byte, then streams it
// as a contiguous pixel burst followed by FRAME_GAP idle cycles. Optional FRAME_SUM_EN adds oFrameSum.
module pixel_frame_feeder #(
  parameter int unsigned IMG_W     = 28,
  parameter int unsigned PIX_W     = 8,
  parameter int unsigned FRAME_GAP = 2
) (
  input  logic             iClk,
  input  logic             iRst,
  input  logic [PIX_W-1:0] iByteIn,
  input  logic             iByteValid,
  output logic             oByteReady,
  output logic [PIX_W-1:0] oPixelOut,
  output logic             oPixelValid,
  output logic             oFrameDone,
`ifdef FRAME_SUM_EN
  output logic [PIX_W+9:0] oFrameSum,
`endif
  output logic             oBusy
);

  localparam int unsigned NPIX  = IMG_W * IMG_W;
  localparam int unsigned CNT_W = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam int unsigned GAP_W = (FRAME_GAP > 1) ? $clog2(FRAME_GAP) : 1;

  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    STREAM = 2'd1,
    GAP    = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_wr_cnt;
  logic [CNT_W-1:0] r_rd_cnt;
  logic [GAP_W-1:0] r_gap_cnt;
  logic             r_rd_done;
  logic [PIX_W-1:0] r_mem [NPIX];
  logic [PIX_W-1:0] r_pix;
  logic             r_pix_valid;
  logic             r_frame_done;
  logic             r_busy;
  logic             r_byte_ready;

  logic             w_accept;
  logic             w_issue;
  logic             w_stream_end;
  logic             w_wr_last;
  logic             w_rd_last;
  logic [PIX_W-1:0] w_rd_pix;

  assign w_wr_last = (r_wr_cnt == CNT_W'(NPIX - 1));
  assign w_rd_last = (r_rd_cnt == CNT_W'(NPIX - 1));
  assign w_rd_pix  = r_mem[r_rd_cnt];

  // STREAM spans NPIX read cycles plus one drain cycle so GAP lines up with the idle output window
  always_comb begin
    w_state_nxt  = r_state;
    w_accept     = 1'b0;
    w_issue      = 1'b0;
    w_stream_end = 1'b0;
    unique case (r_state)
      LOAD: begin
        w_accept = iByteValid;
        if (iByteValid && w_wr_last) w_state_nxt = STREAM;
      end
      STREAM: begin
        w_issue = !r_rd_done;
        if (r_rd_done) begin
          w_stream_end = 1'b1;
          w_state_nxt  = GAP;
        end
      end
      GAP: begin
        if (r_gap_cnt == GAP_W'(FRAME_GAP - 1)) w_state_nxt = LOAD;
      end
      default: w_state_nxt = LOAD;
    endcase
  end

  always_ff @(posedge iClk) begin
    if (iRst) r_state <= LOAD;
    else      r_state <= w_state_nxt;
  end

  // Frame buffer write port; contents survive reset
  always_ff @(posedge iClk) begin
    if (w_accept) r_mem[r_wr_cnt] <= iByteIn;
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      r_wr_cnt     <= '0;
      r_rd_cnt     <= '0;
      r_rd_done    <= 1'b0;
      r_gap_cnt    <= '0;
      r_pix        <= '0;
      r_pix_valid  <= 1'b0;
      r_frame_done <= 1'b0;
      r_busy       <= 1'b0;
      r_byte_ready <= 1'b1;
    end else begin
      r_byte_ready <= (w_state_nxt == LOAD);
      r_busy       <= (w_state_nxt != LOAD);
      r_frame_done <= w_stream_end;
      r_pix_valid  <= w_issue;
      r_pix        <= w_issue ? w_rd_pix : '0;
      if (w_accept) r_wr_cnt <= w_wr_last ? '0 : r_wr_cnt + CNT_W'(1);
      if (w_issue) begin
        r_rd_cnt  <= w_rd_last ? '0 : r_rd_cnt + CNT_W'(1);
        r_rd_done <= w_rd_last;
      end else if (w_stream_end) begin
        r_rd_done <= 1'b0;
      end
      if (r_state == GAP) r_gap_cnt <= (w_state_nxt == LOAD) ? '0 : r_gap_cnt + GAP_W'(1);
    end
  end

  assign oByteReady  = r_byte_ready;
  assign oPixelOut   = r_pix;
  assign oPixelValid = r_pix_valid;
  assign oFrameDone  = r_frame_done;
  assign oBusy       = r_busy;

`ifdef FRAME_SUM_EN
  localparam int unsigned SUM_W = PIX_W + 10;

  logic [SUM_W-1:0] r_acc;
  logic [SUM_W-1:0] r_frame_sum;

  // Accumulate on each read; publish alongside oFrameDone and hold until the next frame ends
  always_ff @(posedge iClk) begin
    if (iRst) begin
      r_acc       <= '0;
      r_frame_sum <= '0;
    end else if (w_issue) begin
      r_acc <= r_acc + SUM_W'(w_rd_pix);
    end else if (w_stream_end) begin
      r_frame_sum <= r_acc;
      r_acc       <= '0;
    end
  end

  assign oFrameSum = r_frame_sum;
`endif

endmodule

// File: tb/tb_pixel_frame_feeder.sv
// Scoreboard bench for pixel_frame_feeder: bytes pushed as they are offered in LOAD,
// popped and compared as pixels stream out. Frame-sum checks compile when FRAME_SUM_EN is defined.
module tb_pixel_frame_feeder;

  localparam int unsigned IMG_W     = 28;
  localparam int unsigned PIX_W     = 8;
  localparam int unsigned FRAME_GAP = 2;
  localparam int unsigned NPIX      = IMG_W * IMG_W;

  logic             iClk = 1'b0;
  logic             iRst;
  logic [PIX_W-1:0] iByteIn;
  logic             iByteValid;
  logic             oByteReady;
  logic [PIX_W-1:0] oPixelOut;
  logic             oPixelValid;
  logic             oFrameDone;
  logic             oBusy;
`ifdef FRAME_SUM_EN
  logic [PIX_W+9:0] oFrameSum;
`endif

  int n_checks = 0;
  int n_pass   = 0;
  logic [PIX_W-1:0] exp_q [$];

  pixel_frame_feeder #(
    .IMG_W    (IMG_W),
    .PIX_W    (PIX_W),
    .FRAME_GAP(FRAME_GAP)
  ) dut (
    .iClk       (iClk),
    .iRst       (iRst),
    .iByteIn    (iByteIn),
    .iByteValid (iByteValid),
    .oByteReady (oByteReady),
    .oPixelOut  (oPixelOut),
    .oPixelValid(oPixelValid),
    .oFrameDone (oFrameDone),
`ifdef FRAME_SUM_EN
    .oFrameSum  (oFrameSum),
`endif
    .oBusy      (oBusy)
  );

  always #5 iClk = ~iClk;

  task automatic step();
    @(posedge iClk);
    #1;
  endtask

  function automatic logic [PIX_W-1:0] pat_byte(input int pat, input int idx);
    if (pat == 1) return 8'hFF;
    if (pat == 2) return 8'((idx * 7 + 3) % 256);
    return 8'(idx % 256);
  endfunction

  // Offers bytes first..first+count-1; every offered byte is expected to be stored
  task automatic load_bytes(input int first, input int count, input int pat, input bit toggle);
    int idx = first;
    int cyc = 0;
    n_checks++;
    if (oByteReady !== 1'b1) $display("FAIL load_ready_start: got %b want 1", oByteReady);
    else n_pass++;
    while (idx < first + count) begin
      if (toggle && (cyc % 2 == 1)) begin
        iByteValid = 1'b0;
        iByteIn    = 8'h55;
      end else begin
        iByteValid = 1'b1;
        iByteIn    = pat_byte(pat, idx);
        exp_q.push_back(iByteIn);
        idx++;
      end
      cyc++;
      step();
    end
    iByteValid = 1'b0;
    iByteIn    = '0;
  endtask

  // Entered in the cycle right after the last byte was accepted
  task automatic check_stream(input bit drive_aa);
    logic [PIX_W-1:0] exp;
    int unsigned sum = 0;
    if (drive_aa) begin
      iByteValid = 1'b1;
      iByteIn    = 8'hAA;
    end
    n_checks++;
    if (oPixelValid !== 1'b0 || oByteReady !== 1'b0 || oBusy !== 1'b1)
      $display("FAIL stream_lead: valid=%b ready=%b busy=%b want 0/0/1", oPixelValid, oByteReady, oBusy);
    else n_pass++;
    step();
    for (int k = 0; k < int'(NPIX); k++) begin
      if (exp_q.size() == 0) exp = '0;
      else exp = exp_q.pop_front();
      sum += 32'(exp);
      n_checks++;
      if (oPixelValid !== 1'b1 || oPixelOut !== exp || oFrameDone !== 1'b0)
        $display("FAIL pixel_%0d: valid=%b data=%0d done=%b want 1/%0d/0", k, oPixelValid, oPixelOut, oFrameDone, exp);
      else n_pass++;
      step();
    end
    n_checks++;
    if (oPixelValid !== 1'b0 || oPixelOut !== '0 || oFrameDone !== 1'b1 || oBusy !== 1'b1)
      $display("FAIL gap_first: valid=%b data=%0d done=%b busy=%b want 0/0/1/1", oPixelValid, oPixelOut, oFrameDone, oBusy);
    else n_pass++;
`ifdef FRAME_SUM_EN
    n_checks++;
    if (oFrameSum !== 18'(sum)) $display("FAIL frame_sum: got %0d want %0d", oFrameSum, sum);
    else n_pass++;
`endif
    step();
    for (int g = 1; g < int'(FRAME_GAP); g++) begin
      n_checks++;
      if (oPixelValid !== 1'b0 || oFrameDone !== 1'b0 || oByteReady !== 1'b0 || oBusy !== 1'b1)
        $display("FAIL gap_%0d: valid=%b done=%b ready=%b busy=%b want 0/0/0/1", g, oPixelValid, oFrameDone, oByteReady, oBusy);
      else n_pass++;
      step();
    end
    if (drive_aa) begin
      iByteValid = 1'b0;
      iByteIn    = '0;
    end
    n_checks++;
    if (oByteReady !== 1'b1 || oBusy !== 1'b0 || oPixelValid !== 1'b0 || oFrameDone !== 1'b0)
      $display("FAIL back_to_load: ready=%b busy=%b valid=%b done=%b want 1/0/0/0", oByteReady, oBusy, oPixelValid, oFrameDone);
    else n_pass++;
    n_checks++;
    if (exp_q.size() != 0) $display("FAIL queue_drained: got %0d left want 0", exp_q.size());
    else n_pass++;
  endtask

  task automatic test_reset();
    iRst       = 1'b1;
    iByteValid = 1'b0;
    iByteIn    = '0;
    repeat (5) step();
    n_checks++;
    if (oPixelValid !== 1'b0 || oPixelOut !== '0 || oFrameDone !== 1'b0 || oBusy !== 1'b0)
      $display("FAIL reset_outputs: valid=%b data=%0d done=%b busy=%b want 0/0/0/0", oPixelValid, oPixelOut, oFrameDone, oBusy);
    else n_pass++;
    iRst = 1'b0;
    step();
    n_checks++;
    if (oByteReady !== 1'b1 || oBusy !== 1'b0 || oPixelValid !== 1'b0)
      $display("FAIL reset_release: ready=%b busy=%b valid=%b want 1/0/0", oByteReady, oBusy, oPixelValid);
    else n_pass++;
`ifdef FRAME_SUM_EN
    n_checks++;
    if (oFrameSum !== '0) $display("FAIL reset_sum: got %0d want 0", oFrameSum);
    else n_pass++;
`endif
  endtask

  task automatic test_full_frame();
    load_bytes(0, NPIX, 0, 1'b0);
    check_stream(1'b0);
  endtask

  task automatic test_backpressure();
    load_bytes(0, NPIX, 0, 1'b1);
    check_stream(1'b0);
  endtask

  task automatic test_stream_ignored();
    load_bytes(0, NPIX, 0, 1'b0);
    check_stream(1'b1);
    load_bytes(0, NPIX, 2, 1'b0);
    check_stream(1'b0);
  endtask

  task automatic test_reset_mid();
    logic [PIX_W-1:0] exp;
    load_bytes(0, NPIX, 0, 1'b0);
    step();
    for (int k = 0; k <= 400; k++) begin
      exp = exp_q.pop_front();
      n_checks++;
      if (oPixelValid !== 1'b1 || oPixelOut !== exp)
        $display("FAIL mid_pixel_%0d: valid=%b data=%0d want 1/%0d", k, oPixelValid, oPixelOut, exp);
      else n_pass++;
      if (k < 400) step();
    end
    iRst = 1'b1;
    step();
    n_checks++;
    if (oPixelValid !== 1'b0 || oPixelOut !== '0 || oFrameDone !== 1'b0 || oBusy !== 1'b0)
      $display("FAIL mid_reset: valid=%b data=%0d done=%b busy=%b want 0/0/0/0", oPixelValid, oPixelOut, oFrameDone, oBusy);
    else n_pass++;
    iRst = 1'b0;
    exp_q.delete();
    step();
    for (int c = 0; c < 6; c++) begin
      n_checks++;
      if (oByteReady !== 1'b1 || oPixelValid !== 1'b0 || oFrameDone !== 1'b0)
        $display("FAIL mid_idle_%0d: ready=%b valid=%b done=%b want 1/0/0", c, oByteReady, oPixelValid, oFrameDone);
      else n_pass++;
      step();
    end
    load_bytes(0, NPIX - 1, 2, 1'b0);
    for (int c = 0; c < 3; c++) begin
      n_checks++;
      if (oByteReady !== 1'b1 || oPixelValid !== 1'b0)
        $display("FAIL partial_load_%0d: ready=%b valid=%b want 1/0", c, oByteReady, oPixelValid);
      else n_pass++;
      step();
    end
    load_bytes(NPIX - 1, 1, 2, 1'b0);
    check_stream(1'b0);
  endtask

`ifdef FRAME_SUM_EN
  task automatic test_frame_sum();
    load_bytes(0, NPIX, 1, 1'b0);
    check_stream(1'b0);
    n_checks++;
    if (oFrameSum !== 18'd199920) $display("FAIL frame_sum_ff: got %0d want 199920", oFrameSum);
    else n_pass++;
  endtask
`endif

  initial begin
    test_reset();
    test_full_frame();
    test_backpressure();
    test_stream_ignored();
    test_reset_mid();
`ifdef FRAME_SUM_EN
    test_frame_sum();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
